// File: rtl/alu_arb_pkg.sv
// rtl/alu_arb_pkg.sv - shared constants and types for the arbitrated ALU
package alu_arb_pkg;

    localparam int DATA_W  = 16;
    localparam int FLAGS_W = 5;

    // Bit positions inside the flag vector {ovf, parity, carry, zero, sign}
    localparam int FLG_SIGN   = 0;
    localparam int FLG_ZERO   = 1;
    localparam int FLG_CARRY  = 2;
    localparam int FLG_PARITY = 3;
    localparam int FLG_OVF    = 4;

    typedef logic [FLAGS_W-1:0] alu_flags_t;

endpackage

// File: rtl/alu.sv
// rtl/alu.sv - 16-bit adder with sign/zero/carry/parity/overflow flags
//
// Ports:
//   x, y  : operands
//   z     : (x + y) mod 2^16, carry-in fixed at 0
//   flags : {overflow, parity, carry, zero, sign}
module alu
    import alu_arb_pkg::*;
(
    input  logic [DATA_W-1:0]  x,
    input  logic [DATA_W-1:0]  y,
    output logic [DATA_W-1:0]  z,
    output logic [FLAGS_W-1:0] flags
);

    logic [DATA_W:0] sum;
    alu_flags_t      f;

    assign sum = {1'b0, x} + {1'b0, y};
    assign z   = sum[DATA_W-1:0];

    always_comb begin
        f             = '0;
        f[FLG_SIGN]   = sum[DATA_W-1];
        f[FLG_ZERO]   = (sum[DATA_W-1:0] == '0);
        f[FLG_CARRY]  = sum[DATA_W];
        // Even parity: set when the result holds an even number of ones
        f[FLG_PARITY] = ~^sum[DATA_W-1:0];
        // Signed overflow: like-signed operands produce a differently signed result
        f[FLG_OVF]    = (x[DATA_W-1] == y[DATA_W-1]) && (sum[DATA_W-1] != x[DATA_W-1]);
    end

    assign flags = f;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter
//
// Ports:
//   req     : request vector
//   prio    : index of the highest-priority requester
//   en      : when low, gnt is forced to zero
//   gnt     : one-hot grant (zero when en low or no request)
//   gnt_idx : encoded winner, valid whenever any is set
//   any     : at least one request is present
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  prio,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            any
);

    logic [IDW:0]   cand_sum;
    logic [IDW-1:0] cand;
    logic           found;

    // Walk prio, prio+1, ... wrapping at NREQ; the first set request wins.
    // Wrap by compare-and-subtract so NREQ need not be a power of two.
    always_comb begin
        cand_sum = '0;
        cand     = '0;
        found    = 1'b0;
        gnt_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand_sum = {1'b0, prio} + (IDW+1)'(k);
            if (cand_sum >= (IDW+1)'(NREQ)) begin
                cand_sum = cand_sum - (IDW+1)'(NREQ);
            end
            cand = cand_sum[IDW-1:0];
            if (!found && req[cand]) begin
                found   = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    always_comb begin
        gnt = '0;
        if (en && found) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

    assign any = found;

endmodule

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin sharing of one ALU among NREQ requesters
//
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   req_valid/req_ready : per-requester operand handshake (ready is one-hot or zero)
//   req_x, req_y        : packed operands, requester i in bits [16i+15:16i]
//   rsp_valid/rsp_ready : response handshake for the one-deep result register
//   rsp_id              : requester that produced the held result
//   rsp_z, rsp_flags    : registered sum and flags from the ALU
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*DATA_W-1:0] req_x,
    input  logic [NREQ*DATA_W-1:0] req_y,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [DATA_W-1:0]      rsp_z,
    output logic [FLAGS_W-1:0]     rsp_flags
);

    logic [IDW-1:0]     prio;
    logic [IDW-1:0]     prio_nxt;
    logic               can_accept;
    logic               arb_en;
    logic [NREQ-1:0]    gnt;
    logic [IDW-1:0]     gnt_idx;
    logic               any;
    logic               grant;
    logic [DATA_W-1:0]  mux_x;
    logic [DATA_W-1:0]  mux_y;
    logic [DATA_W-1:0]  alu_z;
    logic [FLAGS_W-1:0] alu_flags;

    // Response register frees and refills in the same cycle. rst_n gates the
    // enable so no requester sees a handshake while reset is held.
    assign can_accept = !rsp_valid || rsp_ready;
    assign arb_en     = rst_n && can_accept;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (req_valid),
        .prio    (prio),
        .en      (arb_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .any     (any)
    );

    assign req_ready = gnt;
    assign grant     = arb_en && any;

    // AND-OR mux keyed on the one-hot grant keeps operand selection off the
    // encoded index and adds only one gate level before the adder.
    always_comb begin
        mux_x = '0;
        mux_y = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                mux_x = mux_x | req_x[i*DATA_W +: DATA_W];
                mux_y = mux_y | req_y[i*DATA_W +: DATA_W];
            end
        end
    end

    alu u_alu (
        .x     (mux_x),
        .y     (mux_y),
        .z     (alu_z),
        .flags (alu_flags)
    );

    assign prio_nxt = (gnt_idx == IDW'(NREQ-1)) ? '0 : gnt_idx + IDW'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_z     <= '0;
            rsp_flags <= '0;
            prio      <= '0;
        end else if (grant) begin
            rsp_valid <= 1'b1;
            rsp_id    <= gnt_idx;
            rsp_z     <= alu_z;
            rsp_flags <= alu_flags;
            prio      <= prio_nxt;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*16-1:0] req_x;
    logic [NREQ*16-1:0] req_y;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [15:0]       rsp_z;
    logic [4:0]        rsp_flags;

    int n_checks;
    int n_fails;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_x     (req_x),
        .req_y     (req_y),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_z     (rsp_z),
        .rsp_flags (rsp_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_op(input int i, input logic [15:0] x, input logic [15:0] y);
        req_x[i*16 +: 16] = x;
        req_y[i*16 +: 16] = y;
    endtask

    logic [15:0] exp_z [NREQ];
    int          seq_ids [5];

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        rst_n     = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        rsp_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check_eq("rst_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_id",    32'(rsp_id),    32'd0);
        check_eq("rst_z",     32'(rsp_z),     32'd0);
        check_eq("rst_flags", 32'(rsp_flags), 32'd0);
        check_eq("rst_ready", 32'(req_ready), 32'd0);
        rst_n = 1'b1;

        // Requester 2: 0x7FFF + 1 -> 0x8000, sign and overflow
        rsp_ready = 1'b1;
        set_op(2, 16'h7FFF, 16'h0001);
        req_valid = 4'b0100;
        #1 check_eq("s1_ready", 32'(req_ready), 32'h4);
        step();
        req_valid = '0;
        check_eq("s1_valid", 32'(rsp_valid), 32'd1);
        check_eq("s1_id",    32'(rsp_id),    32'd2);
        check_eq("s1_z",     32'(rsp_z),     32'h8000);
        check_eq("s1_flags", 32'(rsp_flags), 32'b10001);

        // Requester 0: 0xFFFF + 1 -> 0, zero/carry/parity (prio now 3, wraps to 0)
        set_op(0, 16'hFFFF, 16'h0001);
        req_valid = 4'b0001;
        #1 check_eq("s2_ready", 32'(req_ready), 32'h1);
        step();
        req_valid = '0;
        check_eq("s2_id",    32'(rsp_id),    32'd0);
        check_eq("s2_z",     32'(rsp_z),     32'h0000);
        check_eq("s2_flags", 32'(rsp_flags), 32'b01110);

        // Requester 1: 0x8000 + 0x8000 -> 0, overflow/parity/carry/zero
        set_op(1, 16'h8000, 16'h8000);
        req_valid = 4'b0010;
        #1 check_eq("s3_ready", 32'(req_ready), 32'h2);
        step();
        req_valid = '0;
        check_eq("s3_id",    32'(rsp_id),    32'd1);
        check_eq("s3_flags", 32'(rsp_flags), 32'b11110);

        // Consumed with no refill
        step();
        check_eq("drain_valid", 32'(rsp_valid), 32'd0);

        // Full contention from a fresh reset
        rst_n = 1'b0;
        #1 rst_n = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            exp_z[i] = 16'(16'h1000 * (i + 1) + i);
            set_op(i, 16'(16'h1000 * (i + 1)), 16'(i));
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            #1 check_eq("fc_ready", 32'(req_ready), 32'(1 << (k % 4)));
            step();
            check_eq("fc_valid", 32'(rsp_valid), 32'd1);
            check_eq("fc_id",    32'(rsp_id),    32'(k % 4));
            check_eq("fc_z",     32'(rsp_z),     32'(exp_z[k % 4]));
        end

        // Backpressure: response from requester 3 must hold
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 check_eq("bp_ready", 32'(req_ready), 32'd0);
            step();
            check_eq("bp_valid", 32'(rsp_valid), 32'd1);
            check_eq("bp_id",    32'(rsp_id),    32'd3);
            check_eq("bp_z",     32'(rsp_z),     32'(exp_z[3]));
        end
        rsp_ready = 1'b1;
        #1 check_eq("bp_release_ready", 32'(req_ready), 32'h1);
        step();
        check_eq("bp_release_valid", 32'(rsp_valid), 32'd1);
        check_eq("bp_release_id",    32'(rsp_id),    32'd0);
        check_eq("bp_release_z",     32'(rsp_z),     32'(exp_z[0]));

        // Sparse requesters 1 and 3 (prio is 1, becomes 2 after first grant)
        req_valid  = 4'b1010;
        seq_ids[0] = 1;
        seq_ids[1] = 3;
        seq_ids[2] = 1;
        seq_ids[3] = 3;
        seq_ids[4] = 1;
        for (int k = 0; k < 5; k++) begin
            #1 check_eq("sp_ready", 32'(req_ready), 32'(1 << seq_ids[k]));
            step();
            check_eq("sp_id", 32'(rsp_id), 32'(seq_ids[k]));
        end

        // Reset while a response is held under backpressure
        rsp_ready = 1'b0;
        step();
        check_eq("mr_held_valid", 32'(rsp_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("mr_valid", 32'(rsp_valid), 32'd0);
        check_eq("mr_id",    32'(rsp_id),    32'd0);
        check_eq("mr_z",     32'(rsp_z),     32'd0);
        check_eq("mr_flags", 32'(rsp_flags), 32'd0);
        rsp_ready = 1'b1;
        #1 check_eq("mr_ready_in_reset", 32'(req_ready), 32'd0);
        step();
        check_eq("mr_valid_in_reset", 32'(rsp_valid), 32'd0);
        rst_n = 1'b1;
        #1 check_eq("mr_first_ready", 32'(req_ready), 32'h2);
        step();
        check_eq("mr_first_valid", 32'(rsp_valid), 32'd1);
        check_eq("mr_first_id",    32'(rsp_id),    32'd1);
        check_eq("mr_first_z",     32'(rsp_z),     32'(exp_z[1]));

        req_valid = '0;
        step();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 16-bit `alu` instance (adder with sign/zero/carry/parity/overflow flags) between `NREQ` independent requesters using round-robin arbitration. Each requester presents an operand pair with a valid/ready handshake. The granted pair is added in a single cycle, and the sum, flags and requester ID are registered into a one-deep response stage with its own valid/ready handshake. The block sits between the instruction-issue logic of several clients and the shared arithmetic datapath.

## Interface
- `NREQ`, default 4: number of requesters, 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.
- `clk`, input, 1: single clock; all state updates on its rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req_valid`, input, NREQ: bit i set means requester i presents operands.
- `req_ready`, output, NREQ: one-hot or zero; bit i set means requester i's operands are accepted this cycle.
- `req_x`, input, NREQ*16: operand x of requester i in bits [16i+15:16i].
- `req_y`, input, NREQ*16: operand y, packed the same way.
- `rsp_valid`, output, 1: response register holds a result.
- `rsp_ready`, input, 1: consumer accepts the response.
- `rsp_id`, output, IDW: index of the requester that produced the response.
- `rsp_z`, output, 16: sum `(x+y) mod 2^16`.
- `rsp_flags`, output, 5: {overflow, parity, carry, zero, sign}, exactly as produced by `alu`.

## Operation
- **Request hold rule.** A requester holds `req_valid` and its operands stable until it sees `req_ready`. The block never drops a raised request.
- **Capacity.** `can_accept = !rsp_valid || rsp_ready`. The response stage frees and refills in the same cycle.
- **Arbitration.**
  - Pointer `prio`, IDW bits, names the highest-priority requester.
  - Search order is `prio, prio+1, …, NREQ-1, 0, …, prio-1`.
  - The first requester with `req_valid` set is the winner `g`.
- **Grant.** If `can_accept` and any `req_valid` is set:
  - `req_ready[g]=1`; all other `req_ready` bits are 0.
  - The mux feeds `req_x[g]` and `req_y[g]` to `alu`.
  - On the clock edge, `rsp_z`, `rsp_flags` and `rsp_id=g` are registered, `rsp_valid` is set, and `prio` becomes `(g+1) mod NREQ`.
- **No grant.** If no grant occurs, `prio` is unchanged and the `req_ready` vector is 0.
- **Response consumed without refill.** If `rsp_valid && rsp_ready` and no grant occurs, `rsp_valid` clears on the edge.
- **Backpressure.** While `rsp_valid && !rsp_ready`, all response outputs hold their values and `req_ready` is 0.
- **Fairness.** A continuously requesting client is granted within NREQ accepted transactions.
- **Arithmetic.** `alu` adds with carry-in 0; there is no subtraction and no chaining. Flags are passed through unmodified.

## Timing
- **Reset values.** On reset: `rsp_valid=0`, `rsp_id=0`, `rsp_z=0`, `rsp_flags=0`, `prio=0`.
- **Reset mid-operation.** Asserting reset during operation discards the held response. No handshake completes while `rst_n` is low.
- **`req_ready` path.** `req_ready` is a combinational function of `req_valid`, `prio`, `rsp_valid` and `rsp_ready`. It must not depend on `req_x` or `req_y`.
- **Latency.** One cycle: operands accepted at edge N appear on `rsp_*` with `rsp_valid=1` after edge N.
- **Throughput.** One transaction per cycle when `rsp_ready` is held high.
- **Simultaneous events.** Consume and refill in the same cycle loads the new result with no bubble.
- **Critical path.** The single combinational path through the arbiter, mux and `alu` must close at the target clock. No other logic is added on it.

## Structure
- **Package `alu_arb_pkg`.**
  - `DATA_W=16`.
  - Flag index constants: `FLG_SIGN=0`, `FLG_ZERO=1`, `FLG_CARRY=2`, `FLG_PARITY=3`, `FLG_OVF=4`.
  - Typedef `alu_flags_t` (5 bits).
- **Sub-module `rr_arbiter`.**
  - Parameter `NREQ`.
  - Inputs: `req`, `prio`, `en`.
  - Outputs: one-hot `gnt`, encoded `gnt_idx`, `any`.
  - Purely combinational; the `prio` register stays in the top level.
- **Top level.** Instantiates `rr_arbiter`, the operand mux, one `alu`, and the response register.

## Test plan
- **Single requests.**
  - Stimulus: requester 2 sends `0x7FFF + 0x0001`.
  - Required: one cycle later `rsp_z=0x8000`, `rsp_id=2`, sign=1, overflow=1, carry=0, zero=0, parity=0.
  - Stimulus: requester 0 sends `0xFFFF + 0x0001`.
  - Required: `rsp_z=0x0000`, zero=1, carry=1, parity=1, overflow=0, sign=0.
- **Full contention.**
  - Stimulus: all 4 requesters valid continuously, `rsp_ready=1` from reset.
  - Required: `rsp_id` sequence 0,1,2,3,0,1… with one response per cycle and no bubbles.
- **Backpressure.**
  - Stimulus: `rsp_valid=1`, then `rsp_ready=0` for 3 cycles with requests pending.
  - Required: `req_ready` is 0 throughout and `rsp_*` is stable. The cycle `rsp_ready` rises, the next grant occurs and loads with no bubble.
- **Fairness with sparse requesters.**
  - Stimulus: only requesters 1 and 3 active, `prio=2`.
  - Required: grant order 3,1,3,1. `prio` goes 0,2,0,2 after each grant.
- **Reset mid-operation.**
  - Stimulus: assert `rst_n=0` asynchronously while `rsp_valid=1` and `rsp_ready=0`.
  - Required: `rsp_valid`, `rsp_id`, `rsp_z` and `rsp_flags` go to 0 immediately. After release, the first grant goes to the lowest-indexed valid requester.
